// File: rtl/uart_pkg.sv
// Shared types and timing constants for the UART transmit path.
// Defaults mirror the 12 MHz / 9600 baud system configuration.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CLK_FREQ   = 12_000_000;
    localparam int DEF_BAUD_RATE  = 9600;
    localparam int DEF_DATA_WIDTH = 8;

    localparam int CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD_RATE);
    localparam int BAUD_CNT_W   = cnt_width(CLKS_PER_BIT);
    localparam int BIT_CNT_W    = cnt_width(DEF_DATA_WIDTH);

endpackage

// File: rtl/uart_tx_module_sync_fifo.sv
// First-word-fall-through synchronous FIFO feeding the UART transmitter.
// Pointers carry an extra wrap bit; full/empty flags are registered.
module sync_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                     full_q, full_d;
    logic                     empty_q, empty_d;
    logic                     push, pop;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pop      = rd_en & ~empty_q;
        // A full FIFO still accepts a write when the same edge frees a slot.
        push     = wr_en & (~full_q | pop);
        wr_ptr_d = wr_ptr_q + {{FIFO_ADDR_WIDTH{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{FIFO_ADDR_WIDTH{1'b0}}, pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[FIFO_ADDR_WIDTH] != rd_ptr_d[FIFO_ADDR_WIDTH]) &&
                   (wr_ptr_d[FIFO_ADDR_WIDTH-1:0] == rd_ptr_d[FIFO_ADDR_WIDTH-1:0]);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx_module.sv
// UART 8N1 transmitter: FIFO-buffered bytes serialised LSB-first on tx_o.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_module
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int CLK_FREQ        = 12_000_000,
    parameter int BAUD_RATE       = 9600
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  tx_o,
    output logic                  tx_busy,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  overflow_o
);

    localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BAUD_W = cnt_width(CPB);
    localparam int BIT_W  = cnt_width(DATA_WIDTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  overflow_q, overflow_d;
    logic                  pop;
    logic                  baud_end;
    logic [DATA_WIDTH-1:0] fifo_dout;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    sync_fifo #(
        .DATA_WIDTH     (DATA_WIDTH),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FIFO_ADDR_WIDTH(FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .wr_en(wr_en),
        .rd_en(pop),
        .din  (din_i),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next frame so queued bytes leave with no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_dout;
`endif
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        overflow_d = overflow_q | (wr_en & fifo_full & ~pop);
    end

    // The line level is registered from the current state, so tx_o trails the FSM by one clock.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START: tx_d = 1'b0;
            DATA:  tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_o       = tx_q;
    assign tx_busy    = (state_q != IDLE);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Scoreboard bench for uart_tx_module; define UART_TX_PARITY_EN to check the parity build.
// The bit period is shortened to 12 clocks so the multi-frame FIFO scenarios stay short.
module tb_uart_tx_module;

    localparam int DATA_WIDTH      = 8;
    localparam int FIFO_DEPTH      = 16;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int CLK_FREQ        = 12_000_000;
    localparam int BAUD_RATE       = 1_000_000;
    localparam int CPB             = 12;   // 12 MHz / 1 MBd
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] din_i = 8'h00;
    logic       tx_o, tx_busy, fifo_full, fifo_empty, overflow_o;

    uart_tx_module #(
        .DATA_WIDTH     (DATA_WIDTH),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FIFO_ADDR_WIDTH(FIFO_ADDR_WIDTH),
        .CLK_FREQ       (CLK_FREQ),
        .BAUD_RATE      (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .din_i     (din_i),
        .tx_o      (tx_o),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t exp_q[$];
    int   start_log[$];
    int   frames_done  = 0;
    bit   frame_active = 1'b0;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic par, input bit expect_tx);
        wr_en = 1'b1;
        din_i = b;
        if (expect_tx) exp_q.push_back('{data: b, par: par});
    endtask

    function automatic int log_at(input int i);
        return (i < start_log.size()) ? start_log[i] : -1000;
    endfunction

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || frame_active || tx_busy !== 1'b0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain within cycle budget", 32'(n < limit), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every falling edge of an idle line starts a frame that is compared
    // cycle-by-cycle against the next scoreboard entry.
    initial begin : monitor
        exp_t                  e;
        logic [FRAME_BITS-1:0] bits;
        logic [7:0]            rx;
        int                    errs;
        bit                    aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx_o === 1'b0) begin
                start_log.push_back(cyc);
                frame_active = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected frame start", 32'd1, 32'd0);
                    repeat (FRAME - 1) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[i + 1] = e.data[i];
`ifdef UART_TX_PARITY_EN
                    bits[9] = e.par;
`endif
                    errs    = 0;
                    rx      = 8'h00;
                    aborted = 1'b0;
                    for (int k = 0; k < FRAME; k++) begin
                        if (k != 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx_o !== bits[k / CPB]) errs++;
                        if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= 8)
                            rx[k / CPB - 1] = tx_o;
                    end
                    if (!aborted) begin
                        check($sformatf("frame 0x%02h received byte", e.data), 32'(rx), 32'(e.data));
                        check($sformatf("frame 0x%02h wrong line cycles", e.data), 32'(errs), 32'd0);
                        frames_done++;
                    end
                end
                frame_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500_000;
        bad++;
        $display("FAIL watchdog: got no end of test within 50000 cycles");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int         wr;
        int         n;
        int         base;
        logic [7:0] b;

        // Reset held for five cycles.
        repeat (5) @(negedge clk);
        check("reset tx_o", 32'(tx_o), 32'd1);
        check("reset tx_busy", 32'(tx_busy), 32'd0);
        check("reset fifo_empty", 32'(fifo_empty), 32'd1);
        check("reset fifo_full", 32'(fifo_full), 32'd0);
        check("reset overflow_o", 32'(overflow_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle tx_o after reset", 32'(tx_o), 32'd1);

        // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1.
        start_log.delete();
        @(negedge clk);
        drive(8'hA5, 1'b0, 1'b1);
        wr = cyc + 1;
        @(negedge clk);
        wr_en = 1'b0;
        check("fifo_empty after write", 32'(fifo_empty), 32'd0);
        n = 0;
        while (tx_busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tx_busy rise latency", 32'(cyc - wr), 32'd1);
        n = 0;
        while (tx_busy === 1'b1 && n < 2 * FRAME) begin
            n++;
            @(negedge clk);
        end
        check("tx_busy length", 32'(n), 32'(FRAME));
        wait_drain(4 * FRAME);
        check("tx_o fall latency", 32'(log_at(0) - wr), 32'd2);
        check("idle line after frame", 32'(tx_o), 32'd1);

        // Back-to-back 0x00, 0xFF: second start follows the first stop with no gap.
        start_log.delete();
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b1);
        wr = cyc + 1;
        @(negedge clk);
        drive(8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        wr_en = 1'b0;
        while (cyc < wr + FRAME) @(negedge clk);
        check("second byte still queued", 32'(fifo_empty), 32'd0);
        @(negedge clk);
        check("fifo empty after second pop", 32'(fifo_empty), 32'd1);
        check("busy across frame boundary", 32'(tx_busy), 32'd1);
        wait_drain(6 * FRAME);
        check("b2b first start latency", 32'(log_at(0) - wr), 32'd2);
        check("b2b frame spacing", 32'(log_at(1) - log_at(0)), 32'(FRAME));

        // Reset during a frame aborts it and flushes the FIFO.
        start_log.delete();
        @(negedge clk);
        drive(8'h3C, 1'b0, 1'b1);
        wr = cyc + 1;
        @(negedge clk);
        drive(8'hC3, 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b0;
        while (cyc < wr + 2 + CPB + 2) @(negedge clk);
        check("line low in data bit 0", 32'(tx_o), 32'd0);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("tx_o high on async reset", 32'(tx_o), 32'd1);
        check("tx_busy low on async reset", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("fifo empty after reset", 32'(fifo_empty), 32'd1);
        repeat (2 * FRAME) @(negedge clk);
        check("no frame resumed after reset", 32'(start_log.size()), 32'd1);
        check("tx_o idle after reset", 32'(tx_o), 32'd1);

        // Fill to full, then write on the edge the FSM pops at the end of STOP.
        start_log.delete();
        base = frames_done;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            b = 8'(8'h20 + i);
            drive(b, ^b, 1'b1);
            if (i == 0) wr = cyc + 1;
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("full after 17 writes", 32'(fifo_full), 32'd1);
        while (cyc < wr + FRAME) @(negedge clk);
        check("full just before pop", 32'(fifo_full), 32'd1);
        drive(8'h5A, 1'b0, 1'b1);
        @(negedge clk);
        wr_en = 1'b0;
        check("full after push with pop", 32'(fifo_full), 32'd1);
        check("no overflow on push with pop", 32'(overflow_o), 32'd0);
        wait_drain(20 * FRAME);
        check("frames after push with pop", 32'(frames_done - base), 32'd18);

        // Overflow: 18 writes from empty, the 18th is dropped.
        start_log.delete();
        base = frames_done;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            b = 8'(i);
            if (i == 17) check("not full after 16 writes", 32'(fifo_full), 32'd0);
            if (i == 18) begin
                check("full after 17 writes", 32'(fifo_full), 32'd1);
                check("overflow clear before drop", 32'(overflow_o), 32'd0);
            end
            drive(b, ^b, i <= 17);
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("overflow set by dropped write", 32'(overflow_o), 32'd1);
        check("still full after dropped write", 32'(fifo_full), 32'd1);
        wait_drain(20 * FRAME);
        check("frames after overflow", 32'(frames_done - base), 32'd17);
        check("overflow sticky", 32'(overflow_o), 32'd1);
        check("fifo empty after drain", 32'(fifo_empty), 32'd1);

`ifdef UART_TX_PARITY_EN
        // Parity bits: 0xA5 -> 0, 0x07 -> 1.
        start_log.delete();
        @(negedge clk);
        drive(8'hA5, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h07, 1'b1, 1'b1);
        @(negedge clk);
        wr_en = 1'b0;
        wait_drain(6 * FRAME);
        check("parity frame spacing", 32'(log_at(1) - log_at(0)), 32'(11 * CPB));
`endif

        check("scoreboard empty at end", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
UART 8N1 transmitter with an input FIFO. It is the transmit-side counterpart of the UART RX path.
- Host pushes bytes into an internal FIFO with a write strobe.
- A bit-timing FSM drains the FIFO and serialises each byte LSB-first on tx_o: start bit, data bits, stop bit.
- It sits between the system logic and the UART TX pin, running from the 12 MHz system clock.

Parameters:
- DATA_WIDTH, 8, data bits per frame and FIFO word width
- FIFO_DEPTH, 16, FIFO entries
- FIFO_ADDR_WIDTH, 4, FIFO pointer width; FIFO_DEPTH = 2**FIFO_ADDR_WIDTH
- CLK_FREQ, 12000000, system clock frequency in Hz
- BAUD_RATE, 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (1250 at defaults, integer division)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous active-high reset
- wr_en  input  1  push din_i into FIFO this cycle
- din_i  input  DATA_WIDTH  byte to transmit
- tx_o  output  1  serial line, idle high
- tx_busy  output  1  high while a frame is on the line (START..STOP)
- fifo_full  output  1  FIFO holds FIFO_DEPTH words
- fifo_empty  output  1  FIFO holds no words
- overflow_o  output  1  sticky flag: a write was dropped; cleared only by rst

Behaviour:
- Reset (async, rst=1): tx_o=1, tx_busy=0, fifo_empty=1, fifo_full=0, overflow_o=0, FSM=IDLE. All counters and pointers are cleared. Any frame in progress is aborted immediately and is not resumed.

FIFO:
- Synchronous and first-word-fall-through: the head word is valid whenever fifo_empty=0.
- Pointers carry one extra MSB for full/empty detection.
- A write while full is dropped and sets overflow_o, unless a pop occurs in the same cycle; in that case the write is accepted.
- Simultaneous push and pop when not full/empty: occupancy is unchanged.
- Flags are registered and update on the edge after the push/pop.

FSM states: IDLE, START, DATA, STOP (plus PARITY under the option).
- IDLE: tx_o=1. If fifo_empty=0: pop, load the shift register with the head word, go to START.
- START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx_o=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. Go to STOP after DATA_WIDTH bits; the bit counter is $clog2(DATA_WIDTH) bits wide.
- STOP: tx_o=1 for CLKS_PER_BIT cycles. In the last cycle, if fifo_empty=0, pop and go directly to START, so back-to-back frames have no idle gap. Otherwise go to IDLE.
- Baud counter: $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.

Timing and outputs:
- Latency: with FIFO empty and FSM IDLE, wr_en sampled at edge N gives fifo_empty=0 after N; the pop occurs at N+1 and tx_o falls after edge N+2.
- One frame is exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
- tx_o is driven from a flop and is glitch-free.
- tx_busy=1 in START, DATA, STOP and PARITY.

Optional Feature:
- UART_TX_PARITY_EN defined: a PARITY state between DATA and STOP drives the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles. The frame becomes (DATA_WIDTH+3)*CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; the frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparam derivation of CLKS_PER_BIT
  - bit-counter width constants
- The PARITY enumerator is always present.
- Sub-module sync_fifo (parameters DATA_WIDTH, FIFO_DEPTH, FIFO_ADDR_WIDTH; ports clk, rst, wr_en, rd_en, din, dout, full, empty) is instantiated once.
- The FSM, baud counter and shift register live in uart_tx_module.

Test Plan:
- Reset check: assert rst for 5 cycles -> tx_o=1, tx_busy=0, fifo_empty=1, fifo_full=0, overflow_o=0. Assert rst while a frame is in progress -> tx_o=1 immediately and the FIFO is empty after release.
- Single byte: write 0xA5 -> tx_o falls 2 edges after the write. Line sequence is 0,1,0,1,0,0,1,0,1,1, each bit held exactly 1250 cycles. tx_busy is high for 12500 cycles, then IDLE.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles -> 20 contiguous bit periods with no idle gap between the first stop bit and the second start bit; the FIFO is empty after the second pop.
- Overflow: write 0x01..0x12 (18 words) on 18 consecutive cycles from IDLE/empty -> fifo_full=1 after the 17th write, the 18th write is dropped, overflow_o=1 and stays high. Exactly 17 frames (0x01..0x11) are transmitted in order.
- Push-while-full-with-pop: with FIFO full, issue wr_en in the cycle the FSM pops at the end of STOP -> the write is accepted, overflow_o is unchanged, and fifo_full stays 1.
- Parity build (UART_TX_PARITY_EN): write 0xA5 -> parity bit 0 after the data bits; write 0x07 -> parity bit 1. Each frame is 11*1250 cycles.
